// File: rtl/regfile_pkg.sv
// Shared types, default sizes and depth helper for the parametrised register file.
package regfile_pkg;

   typedef enum logic [0:0] {
      RF_INIT = 1'b0,
      RF_RUN  = 1'b1
   } rf_state_t;

   localparam int RF_DATA_W = 16;
   localparam int RF_ADDR_W = 3;

   function automatic int rf_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry after reset or on request, then hands the array to the user.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              clear_req_i,
   output logic              busy_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RF_INIT: begin
            // The counter wraps to 0 on the last entry, ready for the next clear.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = RF_RUN;
            end
         end
         RF_RUN: begin
            if (clear_req_i) begin
               state_d = RF_INIT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RF_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= RF_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o     = (state_q == RF_INIT);
   assign clr_we_o   = (state_q == RF_INIT);
   assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with hardware clear, optional write-to-read bypass and
// optional hardwired zero entry (macro REGFILE_ZERO_REG_EN).
module regfile_param
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_req,
   input  logic              write_en,
   input  logic [ADDR_W-1:0] wreg,
   input  logic [DATA_W-1:0] writedata,
   input  logic [ADDR_W-1:0] rega,
   input  logic [ADDR_W-1:0] regb,
   output logic [DATA_W-1:0] read1,
   output logic [DATA_W-1:0] read2,
   output logic              busy,
   output logic              wr_err
);

   localparam int DEPTH = rf_depth(ADDR_W);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              wr_err_q, wr_err_d;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              user_req;
   logic              user_we;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              fwd1, fwd2;

`ifdef REGFILE_ZERO_REG_EN
   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
      return (addr == '0);
   endfunction
`else
   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
      return (addr != addr);
   endfunction
`endif

   function automatic logic [DATA_W-1:0] rd_sel(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] stored,
      input logic [DATA_W-1:0] fwd_data,
      input logic              fwd,
      input logic              blocked
   );
      logic [DATA_W-1:0] v;
      v = stored;
      if (fwd) begin
         v = fwd_data;
      end
      if (is_zero_reg(addr) || blocked) begin
         v = '0;
      end
      return v;
   endfunction

   regfile_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .clear_req_i (clear_req),
      .busy_o      (busy),
      .clr_we_o    (clr_we),
      .clr_addr_o  (clr_addr)
   );

   // A user write only lands in RUN with no clear pending; zero-entry writes vanish silently.
   assign user_req = write_en & ~busy & ~clear_req;
   assign user_we  = user_req & ~is_zero_reg(wreg);

   // The reset edge itself must leave the array untouched, hence the rst_n gate.
   assign mem_we    = rst_n & (clr_we | user_we);
   assign mem_addr  = clr_we ? clr_addr : wreg;
   assign mem_wdata = clr_we ? '0 : writedata;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_addr] <= mem_wdata;
      end
   end

   assign wr_err_d = write_en & (busy | clear_req);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= wr_err_d;
      end
   end

   assign fwd1 = (BYPASS != 0) && user_req && (rega == wreg);
   assign fwd2 = (BYPASS != 0) && user_req && (regb == wreg);

   assign read1  = rd_sel(rega, mem_q[rega], writedata, fwd1, busy);
   assign read2  = rd_sel(regb, mem_q[regb], writedata, fwd2, busy);
   assign wr_err = wr_err_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed table, hand sequences and random traffic
// against an array-level reference model; honours REGFILE_ZERO_REG_EN.
module tb_regfile_param;

   localparam int DEPTH = 8;
`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, clear_req, write_en;
   logic [2:0]  wreg, rega, regb;
   logic [15:0] writedata;
   logic [15:0] read1, read2, read1_nb, read2_nb;
   logic        busy, wr_err, busy_nb, wr_err_nb;

   always #5 clk = ~clk;

   regfile_param #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .write_en(write_en),
      .wreg(wreg), .writedata(writedata), .rega(rega), .regb(regb),
      .read1(read1), .read2(read2), .busy(busy), .wr_err(wr_err)
   );

   regfile_param #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .write_en(write_en),
      .wreg(wreg), .writedata(writedata), .rega(rega), .regb(regb),
      .read1(read1_nb), .read2(read2_nb), .busy(busy_nb), .wr_err(wr_err_nb)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: stored contents, number of clear edges still to run, pending error pulse.
   logic [15:0] m_mem [DEPTH];
   int          m_left = 0;
   bit          m_err = 0;
   bit          m_ok = 0;

   typedef struct {
      bit          rst_n, clr, we;
      logic [2:0]  wreg;
      logic [15:0] wd;
      logic [2:0]  ra, rb;
      logic [15:0] e1, e2;
      bit          ebusy, eerr;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_read(input logic [2:0] a, input bit byp);
      if (m_left > 0) return 16'h0;
      if (ZR && a == 3'd0) return 16'h0;
      if (byp && write_en && !clear_req && a == wreg) return writedata;
      return m_mem[a];
   endfunction

   task automatic drive(input bit r, input bit c, input bit w, input logic [2:0] wa,
                        input logic [15:0] d, input logic [2:0] a, input logic [2:0] b);
      rst_n = r; clear_req = c; write_en = w; wreg = wa; writedata = d; rega = a; regb = b;
   endtask

   // Compare against the model, advance one clock edge, update the model, return at negedge.
   task automatic step();
      #1;
      if (m_ok) begin
         chk("mdl_read1", read1, m_read(rega, 1'b1));
         chk("mdl_read2", read2, m_read(regb, 1'b1));
         chk("mdl_read1_nobyp", read1_nb, m_read(rega, 1'b0));
         chk("mdl_read2_nobyp", read2_nb, m_read(regb, 1'b0));
         chk("mdl_busy", busy, m_left > 0);
         chk("mdl_wr_err", wr_err, m_err);
      end
      @(posedge clk);
      if (!rst_n) begin
         m_left = DEPTH;
         m_err  = 0;
         m_ok   = 1;
      end else begin
         m_err = write_en && (m_left > 0 || clear_req);
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               foreach (m_mem[i]) m_mem[i] = 16'h0;
            end
         end else if (clear_req) begin
            m_left = DEPTH;
         end else if (write_en && !(ZR && wreg == 3'd0)) begin
            m_mem[wreg] = writedata;
         end
      end
      @(negedge clk);
   endtask

   task automatic count_busy(input string nm);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk(nm, 16'(n), 16'd8);
   endtask

   function automatic vec_t mk(input bit c, input bit w, input logic [2:0] wa, input logic [15:0] d,
                               input logic [2:0] a, input logic [2:0] b, input logic [15:0] e1,
                               input logic [15:0] e2, input bit eb, input bit ee);
      vec_t v;
      v.rst_n = 1'b1; v.clr = c; v.we = w; v.wreg = wa; v.wd = d; v.ra = a; v.rb = b;
      v.e1 = e1; v.e2 = e2; v.ebusy = eb; v.eerr = ee;
      return v;
   endfunction

   initial begin
      logic [15:0] z5;
      z5 = ZR ? 16'h0000 : 16'h5555;

      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
      @(negedge clk);

      // Reset held two cycles, then a full clear of exactly eight edges.
      step();
      step();
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
      #1 chk("reset_busy", busy, 1'b1);
      chk("reset_wr_err", wr_err, 1'b0);
      chk("reset_read1_blocked", read1, 16'h0);
      count_busy("reset_busy_edges");
      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 3'(a), 3'(7 - a));
         #1 chk("cleared_read1", read1, 16'h0);
         chk("cleared_read2", read2, 16'h0);
         step();
      end

      // Directed table, expectations observed before each edge.
      tv.push_back(mk(0, 1, 3'd5, 16'hBEEF, 3'd5, 3'd1, 16'hBEEF, 16'h0000, 0, 0));
      tv.push_back(mk(0, 0, 3'd0, 16'h0000, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 0, 0));
      tv.push_back(mk(0, 1, 3'd3, 16'h1234, 3'd3, 3'd5, 16'h1234, 16'hBEEF, 0, 0));
      tv.push_back(mk(0, 0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'h1234, 16'h1234, 0, 0));
      tv.push_back(mk(0, 1, 3'd0, 16'h5555, 3'd0, 3'd0, z5,       z5,       0, 0));
      tv.push_back(mk(0, 0, 3'd0, 16'h0000, 3'd0, 3'd7, z5,       16'h0000, 0, 0));
      tv.push_back(mk(0, 1, 3'd7, 16'h0001, 3'd7, 3'd3, 16'h0001, 16'h1234, 0, 0));
      tv.push_back(mk(1, 1, 3'd2, 16'h00AA, 3'd2, 3'd7, 16'h0000, 16'h0001, 0, 0));
      tv.push_back(mk(0, 0, 3'd0, 16'h0000, 3'd7, 3'd3, 16'h0000, 16'h0000, 1, 1));
      tv.push_back(mk(0, 1, 3'd4, 16'hDEAD, 3'd4, 3'd4, 16'h0000, 16'h0000, 1, 0));
      tv.push_back(mk(0, 0, 3'd0, 16'h0000, 3'd4, 3'd3, 16'h0000, 16'h0000, 1, 1));
      for (int i = 0; i < 5; i++)
         tv.push_back(mk(0, 0, 3'd0, 16'h0000, 3'd7, 3'd3, 16'h0000, 16'h0000, 1, 0));
      tv.push_back(mk(0, 0, 3'd0, 16'h0000, 3'd2, 3'd4, 16'h0000, 16'h0000, 0, 0));
      tv.push_back(mk(0, 0, 3'd0, 16'h0000, 3'd7, 3'd3, 16'h0000, 16'h0000, 0, 0));
      foreach (tv[i]) begin
         drive(tv[i].rst_n, tv[i].clr, tv[i].we, tv[i].wreg, tv[i].wd, tv[i].ra, tv[i].rb);
         #1 chk($sformatf("tv%0d_read1", i), read1, tv[i].e1);
         chk($sformatf("tv%0d_read2", i), read2, tv[i].e2);
         chk($sformatf("tv%0d_busy", i), busy, tv[i].ebusy);
         chk($sformatf("tv%0d_wr_err", i), wr_err, tv[i].eerr);
         step();
      end

      // Bypass versus no-bypass on the same write.
      drive(1'b1, 1'b0, 1'b1, 3'd3, 16'h7777, 3'd0, 3'd0);
      step();
      drive(1'b1, 1'b0, 1'b1, 3'd3, 16'h1234, 3'd3, 3'd3);
      #1 chk("bypass_read1", read1, 16'h1234);
      chk("nobypass_read1_old", read1_nb, 16'h7777);
      step();
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3);
      #1 chk("nobypass_read1_new", read1_nb, 16'h1234);
      step();

      // Fill with ones, then clear colliding with a write to reg 2.
      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b1, 1'b0, 1'b1, 3'(a), 16'hFFFF, 3'd0, 3'd0);
         step();
      end
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd6);
      #1 chk("filled_read1", read1, 16'hFFFF);
      drive(1'b1, 1'b1, 1'b1, 3'd2, 16'h00AA, 3'd2, 3'd6);
      step();
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd6);
      #1 chk("collide_wr_err", wr_err, 1'b1);
      count_busy("collide_busy_edges");
      #1 chk("collide_wr_err_gone", wr_err, 1'b0);
      chk("collide_reg2_cleared", read1, 16'h0);
      step();

      // Reset in the middle of a clear restarts the full sequence.
      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
      step();
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
      for (int i = 0; i < 4; i++) step();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
      step();
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
      count_busy("midinit_busy_edges");

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 99) != 0, $urandom_range(0, 39) == 0, 1'($urandom),
               3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
